// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution window scheduler.
//   state_t      - scheduler FSM encoding (IDLE, RUN, DRAIN, DONE)
//   STALL_CNT_W  - width of the input-stall performance counter
//   out_size()   - windows per frame edge for a given frame/kernel/stride
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned STALL_CNT_W = 16;

    // Elaboration-time helper only; never evaluated in hardware.
    function automatic int unsigned out_size(input int unsigned data_size,
                                             input int unsigned kernel_size,
                                             input int unsigned stride);
        return (data_size - kernel_size) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_scan_counter.sv
// conv_scan_counter: row-major (row, col) scan position with stride phases.
//   clk, rst        - clock, asynchronous active-high reset
//   clear           - synchronous return to (0,0), phases zeroed
//   advance         - step one pixel in scan order
//   row, col        - current scan position (pixel about to be accepted)
//   row_phase_zero  - row is stride-aligned for window completion
//   col_phase_zero  - col is stride-aligned for window completion
//   last            - current position is the final pixel of the frame
module conv_scan_counter #(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned COORD_BW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    output logic [COORD_BW-1:0] row,
    output logic [COORD_BW-1:0] col,
    output logic                row_phase_zero,
    output logic                col_phase_zero,
    output logic                last
);

    localparam int unsigned PH_BW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [COORD_BW-1:0] LAST_IDX  = COORD_BW'(DATA_SIZE - 1);
    localparam logic [COORD_BW-1:0] KM1       = COORD_BW'(KERNEL_SIZE - 1);
    localparam logic [PH_BW-1:0]    PH_RELOAD = PH_BW'(STRIDE - 1);

    logic [PH_BW-1:0] row_ph;
    logic [PH_BW-1:0] col_ph;
    logic             col_wrap;

    assign col_wrap       = (col == LAST_IDX);
    assign last           = col_wrap && (row == LAST_IDX);
    assign row_phase_zero = (row_ph == '0);
    assign col_phase_zero = (col_ph == '0);

    // Phases are held at zero until the first kernel-aligned position,
    // then count down and reload, so a phase of zero marks a stride step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (clear) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col    <= '0;
                col_ph <= '0;
                row    <= last ? '0 : row + COORD_BW'(1);
                if (last || (row < KM1)) begin
                    row_ph <= '0;
                end else begin
                    row_ph <= (row_ph == '0) ? PH_RELOAD : row_ph - PH_BW'(1);
                end
            end else begin
                col <= col + COORD_BW'(1);
                if (col < KM1) begin
                    col_ph <= '0;
                end else begin
                    col_ph <= (col_ph == '0) ? PH_RELOAD : col_ph - PH_BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: sequences one convolution frame, emitting a token
// with the top-left coordinate of every stride-aligned kernel window as soon
// as its last pixel has been accepted.
// Optional feature macro: CONV_SCHED_PERF_EN enables the input-stall counter;
// without it o_stall_cnt is a constant zero.
//   clk, rst       - clock, asynchronous active-high reset
//   i_start        - frame start request (honoured only in IDLE)
//   o_busy, o_done - frame in progress / one-cycle end-of-frame pulse
//   i_pix_valid, o_pix_ready - pixel stream handshake
//   o_win_valid, i_win_ready - window token handshake
//   o_win_row, o_win_col, o_win_idx - token payload
//   o_stall_cnt    - cycles a valid pixel was refused while running
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned COORD_BW    = 5,
    parameter int unsigned IDX_BW      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    output logic                   o_win_valid,
    input  logic                   i_win_ready,
    output logic [COORD_BW-1:0]    o_win_row,
    output logic [COORD_BW-1:0]    o_win_col,
    output logic [IDX_BW-1:0]      o_win_idx,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam logic [COORD_BW-1:0] KM1 = COORD_BW'(KERNEL_SIZE - 1);

    state_t              state;
    state_t              state_next;
    logic                start_acc;
    logic                pix_acc;
    logic                win_hs;
    logic                win_complete;
    logic [COORD_BW-1:0] row;
    logic [COORD_BW-1:0] col;
    logic                row_ph_zero;
    logic                col_ph_zero;
    logic                last_pix;

    assign start_acc    = (state == IDLE) && i_start;
    // A held token blocks new pixels so a completing pixel never overwrites it.
    assign o_pix_ready  = (state == RUN) && !(o_win_valid && !i_win_ready);
    assign pix_acc      = i_pix_valid && o_pix_ready;
    assign win_hs       = o_win_valid && i_win_ready;
    assign win_complete = pix_acc && (row >= KM1) && (col >= KM1)
                          && row_ph_zero && col_ph_zero;
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);

    conv_scan_counter #(
        .DATA_SIZE   (DATA_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .STRIDE      (STRIDE),
        .COORD_BW    (COORD_BW)
    ) u_scan (
        .clk            (clk),
        .rst            (rst),
        .clear          (start_acc),
        .advance        (pix_acc),
        .row            (row),
        .col            (col),
        .row_phase_zero (row_ph_zero),
        .col_phase_zero (col_ph_zero),
        .last           (last_pix)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (pix_acc && last_pix) state_next = DRAIN;
            DRAIN:   if (!o_win_valid || i_win_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window token register; a new completion takes priority over the
    // consumption of the previous token so back-to-back tokens have no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_win_valid <= 1'b0;
            o_win_row   <= '0;
            o_win_col   <= '0;
            o_win_idx   <= '0;
        end else if (start_acc) begin
            o_win_valid <= 1'b0;
            o_win_idx   <= '0;
        end else begin
            if (win_complete) begin
                o_win_valid <= 1'b1;
                o_win_row   <= row - KM1;
                o_win_col   <= col - KM1;
            end else if (win_hs) begin
                o_win_valid <= 1'b0;
            end
            if (win_hs) begin
                o_win_idx <= o_win_idx + IDX_BW'(1);
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Saturating count of refused pixels while the frame is running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && i_pix_valid && !o_pix_ready
                     && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: three 8x8 instances (K3/S1, K3/S2, K8/S1)
// driven with randomized pixel and token handshakes and compared against a
// scan-position model that derives windows from modulo arithmetic.
module tb_conv_window_scheduler;

    localparam int D  = 8;
    localparam int CB = 3;
    localparam int IB = 6;
    localparam int NI = 3;

`ifdef CONV_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    function automatic int k_of(input int i);
        return (i == 2) ? 8 : 3;
    endfunction

    function automatic int s_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start     [NI];
    logic          pix_valid [NI];
    logic          win_ready [NI];
    logic          busy      [NI];
    logic          done      [NI];
    logic          pix_ready [NI];
    logic          win_valid [NI];
    logic [CB-1:0] win_row   [NI];
    logic [CB-1:0] win_col   [NI];
    logic [IB-1:0] win_idx   [NI];
    logic [15:0]   stall     [NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        conv_window_scheduler #(
            .DATA_SIZE   (D),
            .KERNEL_SIZE (k_of(g)),
            .STRIDE      (s_of(g)),
            .COORD_BW    (CB),
            .IDX_BW      (IB)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_start     (start[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .i_pix_valid (pix_valid[g]),
            .o_pix_ready (pix_ready[g]),
            .o_win_valid (win_valid[g]),
            .i_win_ready (win_ready[g]),
            .o_win_row   (win_row[g]),
            .o_win_col   (win_col[g]),
            .o_win_idx   (win_idx[g]),
            .o_stall_cnt (stall[g])
        );
    end

    task automatic check_idle_outputs(input int inst, input string tag);
        vectors++;
        if (busy[inst] !== 1'b0 || done[inst] !== 1'b0 || pix_ready[inst] !== 1'b0
            || win_valid[inst] !== 1'b0 || win_row[inst] !== '0 || win_col[inst] !== '0
            || win_idx[inst] !== '0 || stall[inst] !== '0) begin
            miscompares++;
            $display("FAIL %s inst%0d: got busy=%b done=%b prdy=%b wv=%b row=%0d col=%0d idx=%0d stall=%0d, expected all zero",
                     tag, inst, busy[inst], done[inst], pix_ready[inst], win_valid[inst],
                     win_row[inst], win_col[inst], win_idx[inst], stall[inst]);
        end
    endtask

    // Runs one full frame on an instance and checks every cycle against the model.
    task automatic run_frame(input int inst, input int vpct, input int rpct,
                             input bit hold_first, input bit extra_starts,
                             output int n_tok, output int t_p);
        int k, s, outn, total, acc, hs, n, t_h, t_e, hold, stall_m, r, c, limit;
        int m_row, m_col;
        bit m_valid, seen, v, rd, exp_pr, exp_busy, exp_done, completes;
        k = k_of(inst); s = s_of(inst);
        outn = (D - k) / s + 1; total = outn * outn;
        acc = 0; hs = 0; n = 0; t_p = -1; t_h = -1; t_e = -1; hold = 0; stall_m = 0;
        r = 0; c = 0; m_row = 0; m_col = 0; m_valid = 0; seen = 0; limit = 4000;
        @(negedge clk);
        start[inst] = 1'b1; pix_valid[inst] = 1'b0; win_ready[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
        while ((t_e < 0 || n <= t_e + 2) && n < limit) begin
            exp_busy = (t_e < 0) || (n <= t_e);
            exp_done = (n == t_e);
            vectors++;
            if (busy[inst] !== exp_busy) begin
                miscompares++;
                $display("FAIL busy inst%0d n=%0d: got %b expected %b", inst, n, busy[inst], exp_busy);
            end
            vectors++;
            if (done[inst] !== exp_done) begin
                miscompares++;
                $display("FAIL done inst%0d n=%0d: got %b expected %b", inst, n, done[inst], exp_done);
            end
            vectors++;
            if (win_valid[inst] !== m_valid) begin
                miscompares++;
                $display("FAIL win_valid inst%0d n=%0d: got %b expected %b", inst, n, win_valid[inst], m_valid);
            end
            if (m_valid) begin
                vectors++;
                if (win_row[inst] !== CB'(m_row) || win_col[inst] !== CB'(m_col)) begin
                    miscompares++;
                    $display("FAIL win_coord inst%0d n=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             inst, n, win_row[inst], win_col[inst], m_row, m_col);
                end
            end
            vectors++;
            if (win_idx[inst] !== IB'(hs)) begin
                miscompares++;
                $display("FAIL win_idx inst%0d n=%0d: got %0d expected %0d", inst, n, win_idx[inst], hs);
            end

            v = ($urandom_range(99) < vpct);
            if (hold_first && m_valid && !seen) begin
                seen = 1'b1;
                hold = 10;
            end
            if (hold > 0) begin
                rd = 1'b0;
                hold--;
            end else begin
                rd = ($urandom_range(99) < rpct);
            end
            start[inst]     = extra_starts && (n == 10 || n == t_e);
            pix_valid[inst] = v;
            win_ready[inst] = rd;
            #1;
            exp_pr = (acc < D * D) && !(m_valid && !rd);
            vectors++;
            if (pix_ready[inst] !== exp_pr) begin
                miscompares++;
                $display("FAIL pix_ready inst%0d n=%0d: got %b expected %b", inst, n, pix_ready[inst], exp_pr);
            end
            if ((acc < D * D) && v && !exp_pr) stall_m++;

            // Tokens must leave in row-major order over the stride grid.
            if (m_valid && rd) begin
                vectors++;
                if (win_row[inst] !== CB'((hs / outn) * s) || win_col[inst] !== CB'((hs % outn) * s)) begin
                    miscompares++;
                    $display("FAIL token_order inst%0d idx=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             inst, hs, win_row[inst], win_col[inst], (hs / outn) * s, (hs % outn) * s);
                end
                hs++;
                if (hs == total) t_h = n + 1;
            end

            completes = 1'b0;
            if (v && exp_pr) begin
                r = acc / D;
                c = acc % D;
                completes = (r >= k - 1) && (c >= k - 1)
                            && ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
                acc++;
                if (acc == D * D) t_p = n + 1;
            end
            if (completes) begin
                m_valid = 1'b1;
                m_row   = r - k + 1;
                m_col   = c - k + 1;
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
            if (t_e < 0 && t_p >= 0 && hs == total) t_e = (t_p + 1 > t_h) ? t_p + 1 : t_h;
            n++;
            @(negedge clk);
        end
        start[inst] = 1'b0; pix_valid[inst] = 1'b0; win_ready[inst] = 1'b1;
        vectors++;
        if (n >= limit) begin
            miscompares++;
            $display("FAIL frame_timeout inst%0d: got %0d cycles without done, expected under %0d", inst, n, limit);
        end
        vectors++;
        if (stall[inst] !== (PERF ? 16'(stall_m) : 16'd0)) begin
            miscompares++;
            $display("FAIL stall_cnt inst%0d: got %0d expected %0d", inst, stall[inst], PERF ? stall_m : 0);
        end
        n_tok = hs;
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; pix_valid[i] = 1'b0; win_ready[i] = 1'b1;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < NI; i++) check_idle_outputs(i, "reset_state");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle_outputs(i, "idle_after_reset");
    endtask

    task automatic test_basic();
        int nt, tp;
        run_frame(0, 100, 100, 1'b0, 1'b0, nt, tp);
        check_int("basic_tokens", nt, 36);
        check_int("basic_throughput_last_edge", tp, D * D);
    endtask

    task automatic test_stride2();
        int nt, tp;
        run_frame(1, 100, 100, 1'b0, 1'b0, nt, tp);
        check_int("stride2_tokens", nt, 9);
        run_frame(1, 70, 60, 1'b0, 1'b0, nt, tp);
        check_int("stride2_random_tokens", nt, 9);
    endtask

    task automatic test_backpressure();
        int nt, tp;
        run_frame(0, 100, 100, 1'b1, 1'b0, nt, tp);
        check_int("bp_tokens", nt, 36);
        check_int("bp_last_edge", tp, D * D + 10);
        check_int("bp_stall_cnt", int'(stall[0]), PERF ? 10 : 0);
    endtask

    task automatic test_start_ignored();
        int nt, tp;
        run_frame(0, 80, 80, 1'b0, 1'b1, nt, tp);
        check_int("start_ignored_tokens", nt, 36);
        run_frame(0, 90, 70, 1'b0, 1'b0, nt, tp);
        check_int("restart_tokens", nt, 36);
    endtask

    task automatic test_reset_mid_frame();
        int nt, tp;
        @(negedge clk);
        start[0] = 1'b1; pix_valid[0] = 1'b0; win_ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; pix_valid[0] = 1'b1;
        repeat (30) @(negedge clk);
        pix_valid[0] = 1'b0; win_ready[0] = 1'b0;
        #1;
        vectors++;
        if (win_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_pending: got wv=%b busy=%b expected wv=1 busy=1", win_valid[0], busy[0]);
        end
        #1 rst = 1'b1;
        #1;
        check_idle_outputs(0, "async_reset_clear");
        @(negedge clk);
        rst = 1'b0;
        win_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL no_done_after_reset cyc=%0d: got done=%b busy=%b expected 0 0", i, done[0], busy[0]);
            end
        end
        run_frame(0, 100, 100, 1'b0, 1'b0, nt, tp);
        check_int("post_reset_tokens", nt, 36);
    endtask

    task automatic test_kernel_eq_data();
        int nt, tp;
        run_frame(2, 100, 100, 1'b0, 1'b0, nt, tp);
        check_int("k8_tokens", nt, 1);
        run_frame(2, 60, 30, 1'b0, 1'b0, nt, tp);
        check_int("k8_random_tokens", nt, 1);
    endtask

    task automatic test_random();
        int nt, tp, inst, exp;
        for (int i = 0; i < 6; i++) begin
            inst = int'($urandom_range(NI - 1));
            exp  = (D - k_of(inst)) / s_of(inst) + 1;
            run_frame(inst, int'($urandom_range(100, 25)), int'($urandom_range(100, 25)),
                      1'b0, 1'($urandom_range(1)), nt, tp);
            check_int("random_tokens", nt, exp * exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride2();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_frame();
        test_kernel_eq_data();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
